// File: rtl/whirlpool_pkg.sv
// ---------------------------------------------------------------------------
// whirlpool_pkg
// Shared definitions for the row-serial Whirlpool compression engine:
//   - geometry of the 8x8 byte state (ROW_W, STATE_W, NUM_ROWS)
//   - round constants RC[1..10] (row 0 only; other rows are zero)
//   - controller state encoding
//   - row/byte index helpers (row 0 = state MSBs, byte 0 = row MSB)
// ---------------------------------------------------------------------------
package whirlpool_pkg;

    localparam int ROW_W    = 64;
    localparam int STATE_W  = 512;
    localparam int NUM_ROWS = 8;

    // Round constants indexed by round number. Entries 0 and 11..15 are
    // zero so that any 4-bit round counter value selects something defined.
    localparam logic [15:0][ROW_W-1:0] RC = {
        64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
        64'hca2dbf07ad5a8333,
        64'hfbee7c66dd17479e,
        64'he427418ba77d95d8,
        64'hbd5d10f4cb3e0567,
        64'h58c9290ab1a06b85,
        64'h157737e59ff04ada,
        64'h1de0d7c22e4bfe57,
        64'h60bc9b8ea30c7b35,
        64'h36a6d2f5796f9152,
        64'h1823c6e887b8014f,
        64'h0
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    // Bit position of the MSB of row idx inside a full state vector.
    function automatic int row_msb(input logic [2:0] idx);
        return STATE_W - 1 - ROW_W * int'(idx);
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [STATE_W-1:0] s,
                                                 input logic [2:0]         idx);
        return s[row_msb(idx) -: ROW_W];
    endfunction

    function automatic logic [7:0] byte_of(input logic [ROW_W-1:0] r,
                                           input logic [2:0]       j);
        return r[ROW_W - 1 - 8 * int'(j) -: 8];
    endfunction

endpackage

// File: rtl/process_row.sv
// ---------------------------------------------------------------------------
// process_row
// Applies the Whirlpool non-linear layer (S-box on every byte) followed by
// the MixRows step (row times circulant matrix cir(01,01,04,01,08,05,02,09)
// over GF(2^8) mod x^8+x^4+x^3+x^2+1) to a single 64-bit row.
// Ports:
//   i_row  in   64  input row, byte 0 = MSB
//   o_row  out  64  processed row
// ---------------------------------------------------------------------------
module process_row
    import whirlpool_pkg::*;
(
    input  logic [ROW_W-1:0] i_row,
    output logic [ROW_W-1:0] o_row
);

    // 4-bit mini-boxes E, E^-1 and R, nibble i at bits [4i+3:4i].
    localparam logic [63:0] E_BOX  = 64'h052A478E3F6DC9B1;
    localparam logic [63:0] EI_BOX = 64'h68431C29A5EB7D0F;
    localparam logic [63:0] R_BOX  = 64'h0152A836F94EDBC7;

    // Circulant coefficients; output byte j takes coefficient (j-k) mod 8
    // for input byte k.
    localparam logic [7:0][3:0] THETA_C = {4'h9, 4'h2, 4'h5, 4'h8,
                                           4'h1, 4'h4, 4'h1, 4'h1};

    function automatic logic [3:0] nib(input logic [63:0] tbl,
                                       input logic [3:0]  idx);
        return tbl[{idx, 2'b00} +: 4];
    endfunction

    // The 8-bit S-box built from the mini-box network.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        a = nib(E_BOX, x[7:4]);
        b = nib(EI_BOX, x[3:0]);
        r = nib(R_BOX, a ^ b);
        return {nib(E_BOX, a ^ r), nib(EI_BOX, b ^ r)};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    // Multiply by a small constant (at most 4 bits wide).
    function automatic logic [7:0] gmul_c(input logic [7:0] a,
                                          input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^
               ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
    endfunction

    logic [7:0] w_sub [NUM_ROWS];

    // Byte substitution of every byte in the row.
    always_comb begin
        for (int k = 0; k < NUM_ROWS; k++) begin
            w_sub[k] = sbox(i_row[ROW_W - 1 - 8 * k -: 8]);
        end
    end

    // Row times circulant matrix; every output byte mixes all eight inputs.
    always_comb begin
        o_row = '0;
        for (int j = 0; j < NUM_ROWS; j++) begin
            for (int k = 0; k < NUM_ROWS; k++) begin
                o_row[ROW_W - 1 - 8 * j -: 8] = o_row[ROW_W - 1 - 8 * j -: 8] ^
                    gmul_c(w_sub[k], THETA_C[3'(j - k)]);
            end
        end
    end

endmodule

// File: rtl/whirlpool_pi_gather.sv
// ---------------------------------------------------------------------------
// whirlpool_pi_gather
// Produces one row of the pi-permuted state without materialising the whole
// permutation: byte j of the result is byte j of source row (c - j) mod 8.
// Ports:
//   i_state  in   512  full state, row 0 = MSBs
//   i_row    in   3    index c of the gathered row
//   o_row    out  64   gathered row
// ---------------------------------------------------------------------------
module whirlpool_pi_gather
    import whirlpool_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [2:0]         i_row,
    output logic [ROW_W-1:0]   o_row
);

    // The 3-bit subtraction gives the required mod-8 wrap for free.
    always_comb begin
        o_row = '0;
        for (int j = 0; j < NUM_ROWS; j++) begin
            o_row[ROW_W - 1 - 8 * j -: 8] =
                byte_of(row_of(i_state, i_row - 3'(j)), 3'(j));
        end
    end

endmodule

// File: rtl/whirlpool_compress.sv
// ---------------------------------------------------------------------------
// whirlpool_compress
// Row-serial Whirlpool compression: computes W_H(m) ^ m ^ H, one row per
// clock, ROUNDS*8 round cycles plus one finalisation cycle.
// Ports:
//   clk    in   1    clock, rising edge
//   rst_n  in   1    asynchronous active-low reset
//   start  in   1    request, sampled only in IDLE
//   h_in   in   512  chaining value H (row 0 = MSBs)
//   m_in   in   512  message block m
//   busy   out  1    high from accept edge until done rises
//   done   out  1    one-cycle pulse, h_out valid from then on
//   h_out  out  512  compression result, held until next accepted start
// ---------------------------------------------------------------------------
module whirlpool_compress
    import whirlpool_pkg::*;
#(
    parameter int ROUNDS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [STATE_W-1:0] h_in,
    input  logic [STATE_W-1:0] m_in,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] h_out
);

    state_t             r_state;
    state_t             w_next;
    logic [STATE_W-1:0] r_k;
    logic [STATE_W-1:0] r_l;
    logic [STATE_W-1:0] r_kn;
    logic [STATE_W-1:0] r_ln;
    logic [STATE_W-1:0] r_m;
    logic [STATE_W-1:0] r_h;
    logic [STATE_W-1:0] r_hout;
    logic [3:0]         r_rnd;
    logic [2:0]         r_row;
    logic               r_done;

    logic [ROW_W-1:0]   w_pi_k;
    logic [ROW_W-1:0]   w_pi_l;
    logic [ROW_W-1:0]   w_pr_k;
    logic [ROW_W-1:0]   w_pr_l;
    logic [ROW_W-1:0]   w_kr;
    logic [ROW_W-1:0]   w_lr;
    logic [STATE_W-1:0] w_kn;
    logic [STATE_W-1:0] w_ln;

    whirlpool_pi_gather u_pi_k (.i_state(r_k), .i_row(r_row), .o_row(w_pi_k));
    whirlpool_pi_gather u_pi_l (.i_state(r_l), .i_row(r_row), .o_row(w_pi_l));

    process_row u_row_k (.i_row(w_pi_k), .o_row(w_pr_k));
    process_row u_row_l (.i_row(w_pi_l), .o_row(w_pr_l));

    // The new key row feeds the state path in the same cycle, so the round
    // key is added without waiting for the whole key round to finish.
    assign w_kr = w_pr_k ^ ((r_row == 3'd0) ? RC[r_rnd] : '0);
    assign w_lr = w_pr_l ^ w_kr;

    // Next-round buffers with the current row merged in; at row 7 this is
    // the complete next-round K and L.
    always_comb begin
        w_kn = r_kn;
        w_ln = r_ln;
        w_kn[row_msb(r_row) -: ROW_W] = w_kr;
        w_ln[row_msb(r_row) -: ROW_W] = w_lr;
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: leave ROUND after row 7 of the last round.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ROUND;
            ROUND:   if (r_row == 3'd7 && r_rnd == 4'(ROUNDS)) w_next = FINAL;
            FINAL:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: load on accept, one row per ROUND cycle, K and L only
    // replaced at row 7 because pi needs all eight old rows throughout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_l    <= '0;
            r_kn   <= '0;
            r_ln   <= '0;
            r_m    <= '0;
            r_h    <= '0;
            r_hout <= '0;
            r_rnd  <= '0;
            r_row  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_k   <= h_in;
                        r_l   <= m_in ^ h_in;
                        r_m   <= m_in;
                        r_h   <= h_in;
                        r_rnd <= 4'd1;
                        r_row <= 3'd0;
                    end
                end
                ROUND: begin
                    r_kn  <= w_kn;
                    r_ln  <= w_ln;
                    r_row <= r_row + 3'd1;
                    if (r_row == 3'd7) begin
                        r_k   <= w_kn;
                        r_l   <= w_ln;
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                FINAL: begin
                    r_hout <= r_l ^ r_m ^ r_h;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign h_out = r_hout;

endmodule

// File: tb/tb_whirlpool_compress.sv
// ---------------------------------------------------------------------------
// tb_whirlpool_compress
// Scoreboard bench for whirlpool_compress: stimulus pushes the expected
// digest into a queue, a monitor pops and compares on every done pulse.
// The reference model works on the whole 8x8 state in the textbook order
// (gamma, pi, theta, sigma) and derives its round constants from its own
// S-box table. A second instance with ROUNDS=1 exercises a single round.
// ---------------------------------------------------------------------------
module tb_whirlpool_compress;

    localparam logic [511:0] EMPTY_M = {8'h80, 504'b0};
    localparam logic [511:0] EMPTY_D = {
        64'h19FA61D75522A466, 64'h9B44E39C1D2E1726,
        64'hC530232130D407F8, 64'h9AFEE0964997F7A7,
        64'h3E83BE698B288FEB, 64'hCF88E3E03C4F0757,
        64'hEA8964E59B63D937, 64'h08B138CC42A66EB3};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         start1 = 1'b0;
    logic [511:0] hIn = '0;
    logic [511:0] mIn = '0;
    logic         busy, done, busy1, done1;
    logic [511:0] hOut, hOut1;

    int           nTests = 0;
    int           nFailed = 0;
    int           cyc = 0;
    int           acceptCyc = 0;
    int           busyRun = 0;
    int           lastDoneCyc = -1;
    bit           checkSpacing = 1'b0;
    logic         prevDone = 1'b0;
    logic [511:0] lastExp = '0;
    logic [511:0] q [$];
    logic [511:0] q1 [$];
    logic [7:0]   sboxT [256];
    int           coefC [8] = '{1, 1, 4, 1, 8, 5, 2, 9};

    whirlpool_compress dut (
        .clk(clk), .rst_n(rst_n), .start(start), .h_in(hIn), .m_in(mIn),
        .busy(busy), .done(done), .h_out(hOut));

    whirlpool_compress #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .h_in(hIn), .m_in(mIn),
        .busy(busy1), .done(done1), .h_out(hOut1));

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [511:0] act,
                               input logic [511:0] exp);
        nTests++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // S-box from the mini-box network, with E^-1 obtained by inverting E.
    task automatic buildSbox();
        int e [16] = '{1, 11, 9, 12, 13, 6, 15, 3, 14, 8, 7, 4, 10, 2, 5, 0};
        int r [16] = '{7, 12, 11, 13, 14, 4, 9, 15, 6, 3, 8, 10, 2, 5, 1, 0};
        int ei [16];
        int a, b, t;
        for (int i = 0; i < 16; i++) ei[e[i]] = i;
        for (int x = 0; x < 256; x++) begin
            a = e[x / 16];
            b = ei[x % 16];
            t = r[a ^ b];
            sboxT[x] = 8'(e[a ^ t] * 16 + ei[b ^ t]);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // One un-keyed round on the whole state: gamma, pi, theta.
    function automatic logic [511:0] rowStep(input logic [511:0] s);
        logic [7:0]   g [8][8];
        logic [7:0]   t [8][8];
        logic [7:0]   acc;
        logic [511:0] o = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                g[i][j] = sboxT[s[511 - 8 * (8 * i + j) -: 8]];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                t[i][j] = g[(i - j + 8) % 8][j];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                acc = '0;
                for (int k = 0; k < 8; k++)
                    acc = acc ^ gmul(t[i][k], 8'(coefC[(j - k + 8) % 8]));
                o[511 - 8 * (8 * i + j) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [511:0] refModel(input logic [511:0] h,
                                              input logic [511:0] m,
                                              input int rounds);
        logic [511:0] k = h;
        logic [511:0] l = h ^ m;
        for (int r = 1; r <= rounds; r++) begin
            k = rowStep(k);
            for (int j = 0; j < 8; j++)
                k[511 - 8 * j -: 8] = k[511 - 8 * j -: 8] ^ sboxT[8 * (r - 1) + j];
            l = rowStep(l) ^ k;
        end
        return l ^ m ^ h;
    endfunction

    function automatic logic [511:0] randState();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32 * i +: 32] = $urandom;
        return v;
    endfunction

    // Waits (bounded) for the engine to be idle, then issues one start.
    task automatic applyStimulus(input logic [511:0] h, input logic [511:0] m,
                                 input logic [511:0] exp, input bit hold);
        int waitCnt = 0;
        while (busy && waitCnt < 300) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (busy) begin
            nTests++;
            nFailed++;
            $display("[TB] FAIL accept_timeout: busy=1, expected 0");
        end
        hIn = h;
        mIn = m;
        start = 1'b1;
        q.push_back(exp);
        @(posedge clk); #1;
        acceptCyc = cyc;
        if (!hold) start = 1'b0;
    endtask

    task automatic waitDrain();
        int waitCnt = 0;
        while ((q.size() != 0 || q1.size() != 0) && waitCnt < 300) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (q.size() != 0 || q1.size() != 0) begin
            nTests++;
            nFailed++;
            $display("[TB] FAIL drain_timeout: %0d results pending, expected 0",
                     q.size() + q1.size());
            q.delete();
            q1.delete();
        end
    endtask

    // Monitor for the full-round engine: digest, busy length, done width,
    // latency and back-to-back spacing.
    always @(negedge clk) begin
        if (!rst_n) begin
            busyRun = 0;
            prevDone = 1'b0;
        end else begin
            if (prevDone) checkOutput("done_width", 512'(done), 512'(0));
            if (done) begin
                if (q.size() == 0) begin
                    nTests++;
                    nFailed++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no pending result");
                end else begin
                    lastExp = q.pop_front();
                    checkOutput("digest", hOut, lastExp);
                end
                checkOutput("busy_run", 512'(busyRun), 512'(81));
                checkOutput("latency", 512'(cyc - acceptCyc), 512'(81));
                if (checkSpacing && lastDoneCyc >= 0)
                    checkOutput("done_spacing", 512'(cyc - lastDoneCyc), 512'(82));
                lastDoneCyc = cyc;
                busyRun = 0;
            end
            if (busy) busyRun++;
            prevDone = done;
        end
    end

    // Monitor for the single-round engine.
    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                nTests++;
                nFailed++;
                $display("[TB] FAIL r1_unexpected_done: got done=1, expected no pending result");
            end else begin
                checkOutput("r1_digest", hOut1, q1.pop_front());
            end
        end
    end

    // Absolute time limit.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        logic [511:0] h, m;
        buildSbox();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 512'(busy), 512'(0));
        checkOutput("reset_done", 512'(done), 512'(0));
        checkOutput("reset_hout", hOut, 512'(0));
        checkOutput("reset_busy_r1", 512'(busy1), 512'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known digest of the empty string.
        applyStimulus('0, EMPTY_M, EMPTY_D, 1'b0);
        waitDrain();

        // Single round: zero block first, then two random ones.
        for (int i = 0; i < 3; i++) begin
            h = (i == 0) ? '0 : randState();
            m = (i == 0) ? '0 : randState();
            hIn = h;
            mIn = m;
            start1 = 1'b1;
            q1.push_back(refModel(h, m, 1));
            @(posedge clk); #1;
            start1 = 1'b0;
            waitDrain();
        end

        // Back-to-back with start held high.
        checkSpacing = 1'b1;
        lastDoneCyc = -1;
        for (int i = 0; i < 200; i++) begin
            h = randState();
            m = randState();
            applyStimulus(h, m, refModel(h, m, 10), 1'b1);
        end
        start = 1'b0;
        waitDrain();
        checkSpacing = 1'b0;

        // Starts while busy must be ignored and inputs not re-sampled.
        h = randState();
        m = randState();
        applyStimulus(h, m, refModel(h, m, 10), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        mIn = randState();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        mIn = randState();
        hIn = randState();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDrain();

        // Result held and no stray done through 100 idle cycles.
        for (int i = 0; i < 10; i++) begin
            repeat (10) @(posedge clk);
            #1;
            checkOutput("hold_hout", hOut, lastExp);
            checkOutput("idle_done", 512'(done), 512'(0));
        end

        // Asynchronous reset mid-operation, then a fresh block.
        h = randState();
        m = randState();
        applyStimulus(h, m, refModel(h, m, 10), 1'b0);
        repeat (36) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 512'(busy), 512'(0));
        checkOutput("abort_done", 512'(done), 512'(0));
        checkOutput("abort_hout", hOut, 512'(0));
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        h = randState();
        m = randState();
        applyStimulus(h, m, refModel(h, m, 10), 1'b0);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
        $finish;
    end

endmodule
